// File: rtl/sdram_ex_pattern_ctrl.sv
// SDRAM example test-path sequencer: writes an LFSR byte stream to SDRAM,
// reads it back, and counts mismatches against the regenerated stream.
module sdram_ex_pattern_ctrl #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [7:0]        cfg_seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [7:0]        avm_writedata,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [7:0]        avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              lfsr_enable,
  output logic              lfsr_pause,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_ldata,
  input  logic [7:0]        lfsr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_WRITE,
    S_LOAD_R,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] PEND_LIM = 4'(MAX_PEND);

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] received_q;
  logic [7:0]        seed_q;
  logic [3:0]        pend_q;
  logic [ERR_W-1:0]  err_q;
  logic              pass_q;
  logic              enable_q;

  logic              start_ok;
  logic              wr_fire;
  logic              rd_req;
  logic              rd_fire;
  logic              rd_ret;
  logic [ADDR_W-1:0] last_idx;

  assign start_ok = (state == S_IDLE) && start;
  assign last_idx = len_q - ADDR_W'(1);
  assign wr_fire  = (state == S_WRITE) && !avm_waitrequest;
  assign rd_req   = (state == S_READ) && (issued_q < len_q) && (pend_q < PEND_LIM);
  assign rd_fire  = rd_req && !avm_waitrequest;
  // A return with nothing outstanding cannot belong to this run, so it is dropped.
  assign rd_ret   = avm_readdatavalid && ((state == S_READ) || (state == S_DRAIN))
                    && (pend_q != '0);

  assign err_count     = err_q;
  assign pass          = pass_q;
  assign lfsr_enable   = enable_q;
  assign avm_writedata = lfsr_data;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: state_next = S_WRITE;
      S_WRITE: begin
        if (wr_fire && (index_q == last_idx)) begin
          state_next = S_LOAD_R;
        end
      end
      S_LOAD_R: state_next = S_READ;
      S_READ: begin
        if (rd_fire && (issued_q == last_idx)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((pend_q == '0) && (received_q == len_q)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state outputs to the Avalon master port, LFSR controls and status
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    avm_write   = 1'b0;
    avm_read    = 1'b0;
    avm_address = '0;
    lfsr_pause  = 1'b1;
    lfsr_load   = 1'b0;
    lfsr_ldata  = '0;
    unique case (state)
      S_LOAD_W, S_LOAD_R: begin
        busy       = 1'b1;
        lfsr_load  = 1'b1;
        lfsr_ldata = seed_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        avm_write   = 1'b1;
        avm_address = base_q + index_q;
        lfsr_pause  = !wr_fire;
      end
      S_READ: begin
        busy        = 1'b1;
        avm_read    = rd_req;
        avm_address = base_q + issued_q;
        lfsr_pause  = !avm_readdatavalid;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        lfsr_pause = !avm_readdatavalid;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Run configuration, progress counters, pending-read tracking and result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      index_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      enable_q <= 1'b1;
      if (start_ok) begin
        base_q     <= cfg_base;
        len_q      <= cfg_len;
        seed_q     <= (cfg_seed == 8'h00) ? 8'h01 : cfg_seed;
        index_q    <= '0;
        issued_q   <= '0;
        received_q <= '0;
        pend_q     <= '0;
        err_q      <= '0;
        // An empty run goes straight to DONE with no errors.
        pass_q     <= (cfg_len == '0);
      end else begin
        if (wr_fire) begin
          index_q <= index_q + ADDR_W'(1);
        end
        if (rd_fire) begin
          issued_q <= issued_q + ADDR_W'(1);
        end
        if (rd_ret) begin
          received_q <= received_q + ADDR_W'(1);
          if ((avm_readdata != lfsr_data) && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
          end
        end
        unique case ({rd_fire, rd_ret})
          2'b10:   pend_q <= pend_q + 4'd1;
          2'b01:   pend_q <= pend_q - 4'd1;
          default: pend_q <= pend_q;
        endcase
        if ((state == S_DRAIN) && (state_next == S_DONE)) begin
          pass_q <= (err_q == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_ex_pattern_ctrl.sv
// Bench for sdram_ex_pattern_ctrl: external LFSR, SDRAM slave with stalls,
// variable read latency and read corruption, plus a stream-level reference.
module tb_sdram_ex_pattern_ctrl;

  localparam int unsigned AW = 24;
  localparam int unsigned MP = 4;
  localparam int unsigned EW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len;
  logic [7:0]    cfg_seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [7:0]    avm_writedata;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [7:0]    avm_readdata;
  logic          avm_readdatavalid;
  logic          lfsr_enable;
  logic          lfsr_pause;
  logic          lfsr_load;
  logic [7:0]    lfsr_ldata;
  logic [7:0]    lfsr_data = 8'hA5;

  sdram_ex_pattern_ctrl #(.ADDR_W(AW), .MAX_PEND(MP), .ERR_W(EW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .cfg_base          (cfg_base),
    .cfg_len           (cfg_len),
    .cfg_seed          (cfg_seed),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .lfsr_enable       (lfsr_enable),
    .lfsr_pause        (lfsr_pause),
    .lfsr_load         (lfsr_load),
    .lfsr_ldata        (lfsr_ldata),
    .lfsr_data         (lfsr_data)
  );

  always #5 clk = ~clk;

  // Galois form of the pattern polynomial: shift left, fold 0x1D when b7 leaves.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] stream_byte(input logic [7:0] seed, input int unsigned n);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    for (int unsigned k = 0; k < n; k++) s = lfsr_step(s);
    return s;
  endfunction

  // External pattern LFSR; 0xA5 stands in for its fixed power-up seed.
  always @(posedge clk) begin
    if (!lfsr_enable)    lfsr_data <= 8'hA5;
    else if (lfsr_load)  lfsr_data <= lfsr_ldata;
    else if (!lfsr_pause) lfsr_data <= lfsr_step(lfsr_data);
  end

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } xact_t;
  typedef struct { int unsigned due; logic [7:0] d; } ret_t;

  // Slave configuration set by the stimulus
  int unsigned wait_pct = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned stall_wr_no = 32'hFFFF_FFFF;
  int unsigned stall_left = 0;
  logic [63:0] corrupt_mask = '0;
  bit          spurious = 1'b0;

  // Slave observations
  logic [7:0]    mem [logic [AW-1:0]];
  xact_t         wq[$];
  logic [AW-1:0] rq[$];
  ret_t          pq[$];
  ret_t          r;
  int unsigned   cyc = 0, last_due = 0, wr_count = 0, rd_count = 0;
  int unsigned   outstanding = 0, max_out = 0;
  bit            busy_seen = 1'b0, stall_seen = 1'b0, hold_bad = 1'b0, wreq;
  logic [AW-1:0] hold_a;
  logic [7:0]    hold_d, rdat;

  // Slave: drive returns and waitrequest for this cycle, record what completes at the next edge
  always @(negedge clk) begin
    if (!reset_n) begin
      pq.delete();
      outstanding       = 0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      cyc++;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 8'($urandom);
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        r = pq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = r.d;
        outstanding--;
      end else if (spurious) begin
        avm_readdatavalid = 1'b1;
      end
      wreq = 1'b0;
      if (avm_write && wr_count == stall_wr_no && stall_left > 0) begin
        wreq = 1'b1;
        stall_left--;
        if (!stall_seen) begin
          stall_seen = 1'b1;
          hold_a = avm_address;
          hold_d = avm_writedata;
        end else if (avm_address !== hold_a || avm_writedata !== hold_d) begin
          hold_bad = 1'b1;
        end
      end else if ((avm_write || avm_read) && $urandom_range(99) < wait_pct) begin
        wreq = 1'b1;
      end
      avm_waitrequest = wreq;
      if (avm_write && !wreq) begin
        if (stall_seen && wr_count == stall_wr_no &&
            (avm_address !== hold_a || avm_writedata !== hold_d)) hold_bad = 1'b1;
        wq.push_back('{a: avm_address, d: avm_writedata});
        mem[avm_address] = avm_writedata;
        wr_count++;
      end
      if (avm_read && !wreq) begin
        rq.push_back(avm_address);
        rdat = mem.exists(avm_address) ? mem[avm_address] : 8'h00;
        if (rd_count < 64 && corrupt_mask[rd_count]) rdat = rdat ^ 8'h01;
        r.due = cyc + $urandom_range(lat_max, lat_min);
        if (r.due < last_due) r.due = last_due;
        last_due = r.due;
        r.d = rdat;
        pq.push_back(r);
        rd_count++;
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
      if (busy) busy_seen = 1'b1;
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_err"},   32'(err_count), 0);
    chk({tag, "_wr"},    32'(avm_write), 0);
    chk({tag, "_rd"},    32'(avm_read), 0);
    chk({tag, "_addr"},  32'(avm_address), 0);
    chk({tag, "_en"},    32'(lfsr_enable), 0);
    chk({tag, "_load"},  32'(lfsr_load), 0);
    chk({tag, "_pause"}, 32'(lfsr_pause), 1);
    chk({tag, "_ldata"}, 32'(lfsr_ldata), 0);
  endtask

  task automatic begin_run(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [7:0] seed);
    @(negedge clk);
    wq.delete();
    rq.delete();
    wr_count = 0;
    rd_count = 0;
    max_out = 0;
    busy_seen = 1'b0;
    stall_seen = 1'b0;
    hold_bad = 1'b0;
    start = 1'b1;
    cfg_base = base;
    cfg_len = len;
    cfg_seed = seed;
    @(negedge clk);
    start = 1'b0;
    cfg_base = AW'($urandom);
    cfg_len = AW'($urandom);
    cfg_seed = 8'($urandom);
  endtask

  // Wait for done, then compare the run against the stream-level model.
  task automatic finish_run(input string tag, input logic [AW-1:0] base,
                            input logic [AW-1:0] len, input logic [7:0] seed,
                            output int unsigned cycles);
    int unsigned nbad, ncor, exp_err;
    cycles = 1;
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    ncor = 0;
    for (int unsigned i = 0; i < len && i < 64; i++) if (corrupt_mask[i]) ncor++;
    exp_err = (ncor > 3) ? 3 : ncor;
    chk({tag, "_err"}, 32'(err_count), exp_err);
    chk({tag, "_pass"}, 32'(pass), (exp_err == 0) ? 1 : 0);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_busy_seen"}, 32'(busy_seen), (len != 0) ? 1 : 0);
    chk({tag, "_nwr"}, wq.size(), 32'(len));
    chk({tag, "_nrd"}, rq.size(), 32'(len));
    nbad = 0;
    for (int unsigned i = 0; i < wq.size() && i < len; i++) begin
      if (wq[i].a !== AW'(base + AW'(i)) || wq[i].d !== stream_byte(seed, i)) nbad++;
    end
    chk({tag, "_wseq"}, nbad, 0);
    nbad = 0;
    for (int unsigned i = 0; i < rq.size() && i < len; i++) begin
      if (rq[i] !== AW'(base + AW'(i))) nbad++;
    end
    chk({tag, "_raddr"}, nbad, 0);
    chk({tag, "_maxpend"}, 32'(max_out <= MP), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_pass_hold"}, 32'(pass), (exp_err == 0) ? 1 : 0);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] len,
                     input logic [7:0] seed, output int unsigned cycles);
    begin_run(base, len, seed);
    finish_run(tag, base, len, seed, cycles);
  endtask

  initial begin
    int unsigned cycles, guard;
    logic [AW-1:0] rb, rl;
    logic [7:0] rs;

    reset_n = 1'b0;
    start = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    cfg_seed = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_en", 32'(lfsr_enable), 1);
    chk("idle_pause", 32'(lfsr_pause), 1);

    // Directed stream: 0x20 0x40 0x80 0x1D
    run("basic", 24'h000100, 24'd4, 8'h20, cycles);
    chk("basic_w1", (wq.size() > 1) ? 32'(wq[1].d) : 32'hFFFF, 32'h40);
    chk("basic_w3", (wq.size() > 3) ? 32'(wq[3].d) : 32'hFFFF, 32'h1D);

    // Three-cycle stall on the second write
    stall_wr_no = 1;
    stall_left = 3;
    run("stall", 24'h000100, 24'd4, 8'h20, cycles);
    chk("stall_hold", 32'(hold_bad), 0);
    chk("stall_used", stall_left, 0);
    stall_wr_no = 32'hFFFF_FFFF;

    // Slow slave fills the pending window exactly
    lat_min = 5;
    lat_max = 5;
    run("lat5", 24'h002000, 24'd12, 8'h5A, cycles);
    chk("lat5_peak", max_out, MP);
    lat_min = 1;
    lat_max = 1;

    // One corrupted word, then stray returns while idle must be ignored
    corrupt_mask = 64'h4;
    run("corrupt1", 24'h000300, 24'd8, 8'h77, cycles);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    @(negedge clk);
    chk("idle_rdv_err", 32'(err_count), 1);
    chk("idle_rdv_pass", 32'(pass), 0);

    // Five bad words saturate the 2-bit counter
    corrupt_mask = 64'h1F;
    run("saturate", 24'h000400, 24'd8, 8'h33, cycles);
    corrupt_mask = '0;

    // Empty run: done straight after start, no bus traffic
    run("len0", 24'h000500, 24'd0, 8'h11, cycles);
    chk("len0_lat", cycles, 1);

    // Zero seed substitutes 0x01
    run("seed0", 24'h000600, 24'd3, 8'h00, cycles);
    chk("seed0_w0", (wq.size() > 0) ? 32'(wq[0].d) : 32'hFFFF, 32'h01);

    // Address wrap at the top of the word space
    run("wrap", 24'hFFFFFE, 24'd5, 8'hC3, cycles);

    // Reset during READ with two reads outstanding
    lat_min = 5;
    lat_max = 5;
    begin_run(24'h000700, 24'd8, 8'h42);
    guard = 0;
    while (rd_count < 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached", 32'(rd_count), 2);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lat_min = 1;
    lat_max = 1;
    run("after_rst", 24'h000800, 24'd6, 8'h9C, cycles);

    // Randomized runs: stalls, variable latency, sparse corruption
    for (int n = 0; n < 6; n++) begin
      rb = AW'($urandom);
      rl = AW'($urandom_range(20, 1));
      rs = 8'($urandom);
      wait_pct = $urandom_range(40);
      lat_min = $urandom_range(3, 1);
      lat_max = lat_min + $urandom_range(4);
      corrupt_mask = ($urandom_range(1) == 1) ? 64'(1) << $urandom_range(19) : 64'h0;
      run($sformatf("rand%0d", n), rb, rl, rs, cycles);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
